// File: rtl/params_pkg.sv
// Shared machine-mode CSR addresses, Zicsr funct3 encodings and CSR access helpers.
package params_pkg;

  localparam logic [11:0] CSR_ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;

  localparam logic [2:0] CSR_F3_RW  = 3'b001;
  localparam logic [2:0] CSR_F3_RS  = 3'b010;
  localparam logic [2:0] CSR_F3_RC  = 3'b011;
  localparam logic [2:0] CSR_F3_RWI = 3'b101;
  localparam logic [2:0] CSR_F3_RSI = 3'b110;
  localparam logic [2:0] CSR_F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic [4:0]  rd;
    logic [31:0] pc;
  } csr_req_t;

  function automatic logic csr_is_implemented(input logic [11:0] addr);
    logic hit;
    case (addr)
      CSR_ADDR_MTVEC, CSR_ADDR_MSCRATCH, CSR_ADDR_MEPC, CSR_ADDR_MCAUSE,
      CSR_ADDR_MTVAL, CSR_ADDR_MCYCLE, CSR_ADDR_MINSTRET, CSR_ADDR_MCYCLEH,
      CSR_ADDR_MINSTRETH: hit = 1'b1;
      default:            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Counters are exposed read-only here even though their address range is writable.
  function automatic logic csr_is_readonly(input logic [11:0] addr);
    logic ro;
    case (addr)
      CSR_ADDR_MCYCLE, CSR_ADDR_MINSTRET, CSR_ADDR_MCYCLEH,
      CSR_ADDR_MINSTRETH: ro = 1'b1;
      default:            ro = (addr[11:10] == 2'b11);
    endcase
    return ro;
  endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// Read-modify-write datapath: combines the old CSR value with the source operand.
module csr_wdata_alu
  import params_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] old,
  input  logic [31:0] src,
  output logic [31:0] result
);

  // Select write, set or clear according to funct3.
  always_comb begin
    result = 32'd0;
    case (funct3)
      CSR_F3_RW, CSR_F3_RWI: result = src;
      CSR_F3_RS, CSR_F3_RSI: result = old | src;
      CSR_F3_RC, CSR_F3_RCI: result = old & ~src;
      default:               result = 32'd0;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr executor: read CSR, compute read-modify-write value, issue a single-cycle
// write and return the old value (or an illegal-instruction flag) to the pipeline.
module csr_access_unit
  import params_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [11:0] REQ_CSR_ADDR,
  input  logic [4:0]  REQ_RS1_ADDR,
  input  logic [31:0] REQ_RS1_DATA,
  input  logic [4:0]  REQ_RD_ADDR,
  input  logic [31:0] REQ_PC,
  output logic [11:0] CSR_RADDR,
  input  logic [31:0] CSR_RDATA_REG,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [4:0]  RSP_RD_ADDR,
  output logic [31:0] RSP_RD_DATA,
  output logic [31:0] RSP_PC,
  output logic        RSP_ILLEGAL,
  input  logic        FLUSH
);

  csr_state_t  state_r;
  csr_req_t    req_r;
  logic [11:0] csr_raddr_r;
  logic        rsp_valid_r;
  logic        rsp_illegal_r;
  logic [4:0]  rsp_rd_addr_r;
  logic [31:0] rsp_rd_data_r;
  logic [31:0] rsp_pc_r;

  logic        accept_s;
  logic [31:0] src_s;
  logic        write_en_s;
  logic        illegal_s;
  logic        do_write_s;
  logic [31:0] new_val_s;

  assign REQ_READY = ~FLUSH & ((state_r == ST_IDLE) | ((state_r == ST_RESP) & RSP_READY));
  assign accept_s  = REQ_VALID & REQ_READY;

  // Decode of the latched request: operand, write intent and legality.
  always_comb begin
    src_s      = req_r.funct3[2] ? {27'd0, req_r.rs1_idx} : req_r.rs1_data;
    write_en_s = (req_r.funct3[1:0] == 2'b01) | (req_r.rs1_idx != 5'd0);
    illegal_s  = (req_r.funct3[1:0] == 2'b00) | ~csr_is_implemented(req_r.addr) |
                 (write_en_s & csr_is_readonly(req_r.addr));
    do_write_s = (state_r == ST_WRITE) & ~FLUSH & write_en_s & ~illegal_s;
  end

  csr_wdata_alu u_alu (
    .funct3 (req_r.funct3),
    .old    (CSR_RDATA_REG),
    .src    (src_s),
    .result (new_val_s)
  );

  assign CSR_WADDR   = do_write_s ? req_r.addr : 12'd0;
  assign CSR_WDATA   = do_write_s ? new_val_s  : 32'd0;
  assign CSR_RADDR   = csr_raddr_r;
  assign RSP_VALID   = rsp_valid_r;
  assign RSP_ILLEGAL = rsp_illegal_r;
  assign RSP_RD_ADDR = rsp_rd_addr_r;
  assign RSP_RD_DATA = rsp_rd_data_r;
  assign RSP_PC      = rsp_pc_r;

  // Sequencer with registered request and response payload.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      req_r         <= '0;
      csr_raddr_r   <= 12'd0;
      rsp_valid_r   <= 1'b0;
      rsp_illegal_r <= 1'b0;
      rsp_rd_addr_r <= 5'd0;
      rsp_rd_data_r <= 32'd0;
      rsp_pc_r      <= 32'd0;
    end else if (FLUSH) begin
      state_r     <= ST_IDLE;
      rsp_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        req_r       <= '{funct3: REQ_FUNCT3, addr: REQ_CSR_ADDR, rs1_idx: REQ_RS1_ADDR,
                         rs1_data: REQ_RS1_DATA, rd: REQ_RD_ADDR, pc: REQ_PC};
        csr_raddr_r <= REQ_CSR_ADDR;
      end
      case (state_r)
        ST_IDLE:  state_r <= accept_s ? ST_READ : ST_IDLE;
        ST_READ:  state_r <= ST_WRITE;
        ST_WRITE: begin
          state_r       <= ST_RESP;
          rsp_valid_r   <= 1'b1;
          rsp_illegal_r <= illegal_s;
          rsp_rd_addr_r <= req_r.rd;
          rsp_rd_data_r <= illegal_s ? 32'd0 : CSR_RDATA_REG;
          rsp_pc_r      <= req_r.pc;
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_r <= 1'b0;
            state_r     <= accept_s ? ST_READ : ST_IDLE;
          end
        end
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed and randomized Zicsr stimulus checked against a transaction-level reference model.
module tb_csr_access_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [2:0]  REQ_FUNCT3 = 3'd0;
  logic [11:0] REQ_CSR_ADDR = 12'd0;
  logic [4:0]  REQ_RS1_ADDR = 5'd0;
  logic [31:0] REQ_RS1_DATA = 32'd0;
  logic [4:0]  REQ_RD_ADDR = 5'd0;
  logic [31:0] REQ_PC = 32'd0;
  logic [11:0] CSR_RADDR;
  logic [31:0] CSR_RDATA_REG = 32'd0;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [4:0]  RSP_RD_ADDR;
  logic [31:0] RSP_RD_DATA;
  logic [31:0] RSP_PC;
  logic        RSP_ILLEGAL;
  logic        FLUSH = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    logic        ill;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
  } exp_t;

  csr_access_unit dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_CSR_ADDR(REQ_CSR_ADDR), .REQ_RS1_ADDR(REQ_RS1_ADDR),
    .REQ_RS1_DATA(REQ_RS1_DATA), .REQ_RD_ADDR(REQ_RD_ADDR), .REQ_PC(REQ_PC),
    .CSR_RADDR(CSR_RADDR), .CSR_RDATA_REG(CSR_RDATA_REG), .CSR_WADDR(CSR_WADDR),
    .CSR_WDATA(CSR_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RD_ADDR(RSP_RD_ADDR), .RSP_RD_DATA(RSP_RD_DATA), .RSP_PC(RSP_PC),
    .RSP_ILLEGAL(RSP_ILLEGAL), .FLUSH(FLUSH)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: the instruction's architectural effect from the Zicsr rules.
  function automatic exp_t ref_model(input op_t o);
    exp_t        e;
    int          kind;
    logic [31:0] src, newv;
    logic        writes, impl, ro;
    logic [11:0] impl_list [9] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                   12'hB00, 12'hB02, 12'hB80, 12'hB82};
    kind   = int'(o.f3) % 4;
    src    = o.f3 >= 3'd4 ? 32'(o.idx) : o.data;
    writes = (kind == 1) || (o.idx != 5'd0);
    impl   = 1'b0;
    foreach (impl_list[i]) if (impl_list[i] == o.addr) impl = 1'b1;
    ro     = (o.addr >= 12'hC00) || (impl && o.addr >= 12'hB00);
    e.ill  = (kind == 0) || !impl || (writes && ro);
    if (kind == 1)      newv = src;
    else if (kind == 2) newv = o.rdata | src;
    else                newv = o.rdata & ~src;
    e.waddr   = (!e.ill && writes) ? o.addr : 12'd0;
    e.wdata   = (!e.ill && writes) ? newv : 32'd0;
    e.rd_data = e.ill ? 32'd0 : o.rdata;
    return e;
  endfunction

  task automatic drive_req(input op_t o);
    REQ_VALID = 1'b1; REQ_FUNCT3 = o.f3; REQ_CSR_ADDR = o.addr; REQ_RS1_ADDR = o.idx;
    REQ_RS1_DATA = o.data; REQ_RD_ADDR = o.rd; REQ_PC = o.pc;
  endtask

  // Waits (bounded) for REQ_READY and accepts; returns #1 after the accept edge.
  task automatic start_op(input op_t o);
    int waited = 0;
    @(negedge CLK);
    drive_req(o);
    while (!REQ_READY && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check_val("req_ready_wait", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  // From the READ cycle through response handshake; optionally chains the next request.
  task automatic finish_op(input op_t o, input int hold, input bit chain, input op_t nxt);
    exp_t e = ref_model(o);
    check_val("read_raddr", 32'(CSR_RADDR), 32'(o.addr));
    check_val("read_waddr", 32'(CSR_WADDR), 32'd0);
    check_val("read_rspv", 32'(RSP_VALID), 32'd0);
    CSR_RDATA_REG = ~o.rdata;
    @(posedge CLK); #1;
    CSR_RDATA_REG = o.rdata;
    #1;
    check_val("write_waddr", 32'(CSR_WADDR), 32'(e.waddr));
    check_val("write_wdata", CSR_WDATA, e.wdata);
    check_val("write_rspv", 32'(RSP_VALID), 32'd0);
    @(posedge CLK); #1;
    CSR_RDATA_REG = $urandom;
    for (int h = 0; h <= hold; h++) begin
      check_val("rsp_valid", 32'(RSP_VALID), 32'd1);
      check_val("rsp_rd_addr", 32'(RSP_RD_ADDR), 32'(o.rd));
      check_val("rsp_rd_data", RSP_RD_DATA, e.rd_data);
      check_val("rsp_pc", RSP_PC, o.pc);
      check_val("rsp_illegal", 32'(RSP_ILLEGAL), 32'(e.ill));
      check_val("rsp_waddr", 32'(CSR_WADDR), 32'd0);
      check_val("rsp_req_ready", 32'(REQ_READY), 32'd0);
      if (h < hold) begin
        @(posedge CLK); #1;
      end
    end
    RSP_READY = 1'b1;
    if (chain) drive_req(nxt);
    #1;
    check_val("release_req_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    REQ_VALID = 1'b0;
    check_val("after_rsp_valid", 32'(RSP_VALID), 32'd0);
    if (!chain) check_val("after_req_ready", 32'(REQ_READY), 32'd1);
  endtask

  function automatic op_t mk(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                             input logic [31:0] data, input logic [4:0] rd, input logic [31:0] rdata);
    op_t o;
    o.f3 = f3; o.addr = addr; o.idx = idx; o.data = data; o.rd = rd;
    o.pc = $urandom; o.rdata = rdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    logic [11:0] addrs [11] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00,
                                12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'h300};
    int   sel = $urandom_range(0, 11);
    logic [11:0] a = (sel == 11) ? 12'($urandom) : addrs[sel];
    logic [4:0]  idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return mk(3'($urandom_range(0, 7)), a, idx, $urandom, 5'($urandom), $urandom);
  endfunction

  initial begin
    op_t a, b, cur, nxt;
    bit  chain;

    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check_val("rst_raddr", 32'(CSR_RADDR), 32'd0);
    check_val("rst_waddr", 32'(CSR_WADDR), 32'd0);
    check_val("rst_rd_data", RSP_RD_DATA, 32'd0);
    @(negedge CLK); RST = 1'b0; #1;
    check_val("rst_req_ready", 32'(REQ_READY), 32'd1);

    // Directed cases.
    a = mk(3'b001, 12'h340, 5'd7, 32'hDEADBEEF, 5'd5, 32'h12345678);
    start_op(a); finish_op(a, 0, 0, a);
    a = mk(3'b010, 12'hB00, 5'd0, 32'hFFFFFFFF, 5'd3, 32'h00000042);
    start_op(a); finish_op(a, 0, 0, a);
    a = mk(3'b111, 12'h305, 5'd3, 32'h0, 5'd9, 32'h80000107);
    start_op(a); finish_op(a, 0, 0, a);
    a = mk(3'b001, 12'hB00, 5'd1, 32'h55AA55AA, 5'd4, 32'h11111111);
    start_op(a); finish_op(a, 0, 0, a);
    a = mk(3'b100, 12'h340, 5'd1, 32'h1, 5'd6, 32'h22222222);
    start_op(a); finish_op(a, 0, 0, a);
    a = mk(3'b010, 12'h341, 5'd2, 32'hF0F0F0F0, 5'd8, 32'h0F0F0000);
    b = mk(3'b101, 12'h342, 5'd17, 32'h0, 5'd10, 32'hCAFEF00D);
    start_op(a); finish_op(a, 3, 1, b); finish_op(b, 0, 0, b);

    // Flush during WRITE suppresses the write and the response.
    a = mk(3'b001, 12'h343, 5'd1, 32'hA5A5A5A5, 5'd11, 32'h33333333);
    start_op(a);
    @(posedge CLK); #1;
    CSR_RDATA_REG = a.rdata; FLUSH = 1'b1; #1;
    check_val("flush_waddr", 32'(CSR_WADDR), 32'd0);
    check_val("flush_wdata", CSR_WDATA, 32'd0);
    check_val("flush_req_ready", 32'(REQ_READY), 32'd0);
    @(posedge CLK); #1;
    FLUSH = 1'b0; #1;
    check_val("flush_rsp_valid", 32'(RSP_VALID), 32'd0);
    check_val("flush_idle_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    check_val("flush_rsp_valid2", 32'(RSP_VALID), 32'd0);

    // Randomized traffic with back-pressure and back-to-back chaining.
    cur = rand_op();
    start_op(cur);
    for (int i = 0; i < 40; i++) begin
      nxt   = rand_op();
      chain = 1'($urandom_range(0, 1));
      finish_op(cur, $urandom_range(0, 2), chain, nxt);
      if (!chain) start_op(nxt);
      cur = nxt;
    end
    finish_op(cur, 0, 0, cur);

    // Reset in READ clears outputs at once and no write follows.
    a = mk(3'b001, 12'h340, 5'd1, 32'h01020304, 5'd12, 32'h99999999);
    start_op(a); finish_op(a, 0, 0, a);
    b = mk(3'b001, 12'h341, 5'd1, 32'h0BADF00D, 5'd13, 32'h44444444);
    start_op(b);
    CSR_RDATA_REG = b.rdata;
    RST = 1'b1; #1;
    check_val("arst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check_val("arst_raddr", 32'(CSR_RADDR), 32'd0);
    check_val("arst_rd_data", RSP_RD_DATA, 32'd0);
    check_val("arst_rd_addr", 32'(RSP_RD_ADDR), 32'd0);
    check_val("arst_pc", RSP_PC, 32'd0);
    check_val("arst_waddr", 32'(CSR_WADDR), 32'd0);
    @(negedge CLK); RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      check_val("arst_no_write", 32'(CSR_WADDR), 32'd0);
      check_val("arst_no_rsp", 32'(RSP_VALID), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
